// File: rtl/cmp_iter_if.sv
// Handshake and operand bundle for the iterative branch comparator.
// The DUT takes the slave modport; the issuing stage takes the master modport.
interface cmp_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic [2:0]       mode_i;
  logic             flush_i;
  logic             ready_o;
  logic             done_o;
  logic             result_o;
  logic             less_o;
  logic             equal_o;
  logic             illegal_o;

  modport master (
    output start_i, A_i, B_i, mode_i, flush_i,
    input  ready_o, done_o, result_o, less_o, equal_o, illegal_o
  );

  modport slave (
    input  start_i, A_i, B_i, mode_i, flush_i,
    output ready_o, done_o, result_o, less_o, equal_o, illegal_o
  );
endinterface

// File: rtl/cmp_iter.sv
// Iterative RV32I branch comparator: scans operands CHUNK bits per cycle from
// the MSB end, optionally stopping at the first differing chunk.
module cmp_iter #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  cmp_iter_if.slave  bus
);
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh, bias;
  logic [2:0]       mode_q;
  logic             dec_q, dec_d, dec_less_q, dec_less_d;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             diff, chunk_less, accept, finish;
  logic             fin_less, fin_eq, fin_result, fin_illegal;
  logic             result_q, less_q, equal_q, illegal_q;

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so every chunk compare below can stay unsigned.
  assign bias = bus.mode_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};

  assign a_sh       = a_q << (idx_q * CHUNK);
  assign b_sh       = b_q << (idx_q * CHUNK);
  assign chunk_a    = a_sh[WIDTH-1 -: CHUNK];
  assign chunk_b    = b_sh[WIDTH-1 -: CHUNK];
  assign diff       = (chunk_a != chunk_b);
  assign chunk_less = (chunk_a < chunk_b);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dec_d      = dec_q;
    dec_less_d = dec_less_q;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          accept  = 1'b1;
          idx_d   = '0;
          dec_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          if (diff && !dec_q) begin
            dec_d      = 1'b1;
            dec_less_d = chunk_less;
          end
          if (((EARLY_EXIT != 0) && diff) || (idx_q == IDX_LAST)) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final decision on the completing edge: an earlier recorded chunk wins.
  always_comb begin
    fin_eq      = !dec_q && !diff;
    fin_less    = dec_q ? dec_less_q : (diff && chunk_less);
    fin_illegal = (mode_q[2:1] == 2'b01);
    unique case (mode_q)
      3'b000:        fin_result = fin_eq;
      3'b001:        fin_result = !fin_eq;
      3'b100, 3'b110: fin_result = fin_less;
      3'b101, 3'b111: fin_result = !fin_less;
      default:       fin_result = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous
  // and also clears the operand latches so no X can leak into a later compare.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= '0;
      dec_q      <= 1'b0;
      dec_less_q <= 1'b0;
      result_q   <= 1'b0;
      less_q     <= 1'b0;
      equal_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dec_q      <= dec_d;
      dec_less_q <= dec_less_d;
      if (accept) begin
        a_q    <= bus.A_i ^ bias;
        b_q    <= bus.B_i ^ bias;
        mode_q <= bus.mode_i;
      end
      if (finish) begin
        result_q  <= fin_result;
        less_q    <= fin_less;
        equal_q   <= fin_eq;
        illegal_q <= fin_illegal;
      end
    end
  end

  assign bus.ready_o   = (state_q == IDLE) && !sys_rst;
  assign bus.done_o    = (state_q == DONE);
  assign bus.result_o  = result_q;
  assign bus.less_o    = less_q;
  assign bus.equal_o   = equal_q;
  assign bus.illegal_o = illegal_q;
endmodule

// File: tb/tb_cmp_iter.sv
// Scoreboard bench for cmp_iter: three instances (8-bit chunks with and without
// early exit, and single-chunk), expected responses queued at issue time.
module tb_cmp_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sys_rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  typedef struct {
    int         dut;
    int         acc;
    int         lat;
    logic [3:0] flags;   // {result, less, equal, illegal}
  } exp_t;

  exp_t sb[$];

  logic        start_v[3];
  logic [31:0] a_v[3];
  logic [31:0] b_v[3];
  logic [2:0]  mode_v[3];
  logic        flush_v[3];
  logic [2:0]  rdy_w, done_w;
  logic [2:0][3:0] out_w;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cmp_iter_if #(.WIDTH(32)) bus ();
    assign bus.start_i = start_v[g];
    assign bus.A_i     = a_v[g];
    assign bus.B_i     = b_v[g];
    assign bus.mode_i  = mode_v[g];
    assign bus.flush_i = flush_v[g];
    assign rdy_w[g]    = bus.ready_o;
    assign done_w[g]   = bus.done_o;
    assign out_w[g]    = {bus.result_o, bus.less_o, bus.equal_o, bus.illegal_o};
    cmp_iter #(
      .WIDTH(32),
      .CHUNK((g == 2) ? 32 : 8),
      .EARLY_EXIT((g == 1) ? 0 : 1)
    ) dut (
      .sys_clk(clk),
      .sys_rst(sys_rst),
      .bus(bus)
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  exp_t m_e;
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (done_w[g]) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done_w[g]), 0);
        end else begin
          m_e = sb.pop_front();
          check("done_dut", g, m_e.dut);
          check("latency", cyc - m_e.acc, m_e.lat);
          check("flags_rlei", 32'(out_w[g]), 32'(m_e.flags));
        end
      end
    end
  end

  task automatic wait_drained();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #2;
      if (sb.size() == 0) break;
    end
    check("done_seen", sb.size(), 0);
    sb.delete();
  endtask

  task automatic issue(int d, logic [31:0] a, logic [31:0] b, logic [2:0] m,
                       logic [3:0] fl, int lat);
    exp_t e;
    @(negedge clk);
    check("ready_before_start", 32'(rdy_w[d]), 1);
    start_v[d] = 1'b1; a_v[d] = a; b_v[d] = b; mode_v[d] = m;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    e.dut = d; e.acc = cyc; e.lat = lat; e.flags = fl;
    sb.push_back(e);
    wait_drained();
  endtask

  function automatic logic [3:0] golden(logic [31:0] a, logic [31:0] b, logic [2:0] m);
    logic eq, lt, r, il;
    eq = (a == b);
    lt = m[1] ? (a < b) : ($signed(a) < $signed(b));
    il = (m == 3'b010) || (m == 3'b011);
    case (m)
      3'b000:  r = eq;
      3'b001:  r = !eq;
      3'b100, 3'b110: r = lt;
      3'b101, 3'b111: r = !lt;
      default: r = 1'b0;
    endcase
    return {r, lt, eq, il};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rm;
    sys_rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0; a_v[g] = '0; b_v[g] = '0; mode_v[g] = '0; flush_v[g] = 1'b0;
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("ready_in_reset", 32'(rdy_w[g]), 0);
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("ready_after_reset", 32'(rdy_w[g]), 1);
      check("done_after_reset", 32'(done_w[g]), 0);
      check("flags_after_reset", 32'(out_w[g]), 0);
    end

    // Early-exit, 8-bit chunks.
    issue(0, 32'h8001_2345, 32'h0001_2345, 3'b100, 4'b1100, 1);
    issue(0, 32'd11111,     32'd11111,     3'b000, 4'b1010, 4);
    issue(0, 32'd11111,     32'd11111,     3'b001, 4'b0010, 4);
    issue(0, 32'hffff_1234, 32'hffff_1233, 3'b111, 4'b1000, 4);
    issue(0, 32'hffff_1234, 32'hffff_1233, 3'b100, 4'b0000, 4);
    issue(0, 32'd12345,     32'd12344,     3'b110, 4'b0000, 4);
    issue(0, 32'd56565,     32'd65656,     3'b110, 4'b1100, 2);
    issue(0, 32'h7fff_ffff, 32'h8000_0000, 3'b101, 4'b1000, 1);
    issue(0, 32'h0000_0000, 32'hffff_ffff, 3'b110, 4'b1100, 1);

    // Flush in BUSY with start held high; outputs must keep 1100.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 32'h1; b_v[0] = 32'h2; mode_v[0] = 3'b000;
    @(posedge clk); #1;
    a_v[0] = 32'hffff_ffff; mode_v[0] = 3'b001;
    @(negedge clk);
    check("busy_ready", 32'(rdy_w[0]), 0);
    @(negedge clk);
    check("busy_ready_start_held", 32'(rdy_w[0]), 0);
    start_v[0] = 1'b0; flush_v[0] = 1'b1;
    @(negedge clk);
    flush_v[0] = 1'b0;
    check("flush_ready", 32'(rdy_w[0]), 1);
    check("flush_no_done", 32'(done_w[0]), 0);
    check("flush_flags_kept", 32'(out_w[0]), 32'(4'b1100));
    repeat (6) @(negedge clk);

    // Flush together with start in IDLE: start is dropped.
    start_v[0] = 1'b1; flush_v[0] = 1'b1; a_v[0] = 32'h5; b_v[0] = 32'h5; mode_v[0] = 3'b000;
    @(posedge clk); #1;
    start_v[0] = 1'b0; flush_v[0] = 1'b0;
    @(negedge clk);
    check("flush_drops_start", 32'(rdy_w[0]), 1);
    repeat (6) @(negedge clk);
    check("flags_after_drop", 32'(out_w[0]), 32'(4'b1100));

    // Full scan, 8-bit chunks.
    issue(1, 32'h8000_0000, 32'h0000_0000, 3'b110, 4'b0000, 4);
    issue(1, 32'h0000_0001, 32'h0000_0002, 3'b010, 4'b0101, 4);
    issue(1, 32'h12ff_0000, 32'h1300_ff00, 3'b110, 4'b1100, 4);
    issue(1, 32'h0000_0005, 32'h0000_0005, 3'b101, 4'b1010, 4);

    // Single chunk against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      rm = 3'($urandom_range(0, 7));
      issue(2, ra, rb, rm, golden(ra, rb, rm), 1);
    end

    // Reset in the middle of a multi-cycle compare.
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 32'h1; b_v[0] = 32'h2; mode_v[0] = 3'b000;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(negedge clk);
    sys_rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_ready", 32'(rdy_w[g]), 0);
      check("rst_done", 32'(done_w[g]), 0);
      check("rst_flags", 32'(out_w[g]), 0);
    end
    sys_rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(rdy_w[0]), 1);
    repeat (6) @(negedge clk);
    check("rst_no_late_done", 32'(out_w[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
